// File: rtl/simon_ctrl_seq.sv
// Control sequencer for the Simon datapath. The core applies up to UNROLL rounds per step.
// Define SIMON_CTRL_KEY_CACHE_EN to let decryptions reuse the cached key schedule.
module simon_ctrl_seq #(
  parameter int WW     = 16,
  parameter int NKW    = 4,
  parameter int UNROLL = 1
) (
  input  logic                         clk,
  input  logic                         srst,
  output logic                         active_o,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic                         mode_i,
  input  logic                         key_reuse_i,
  output logic                         core_srst_o,
  output logic                         core_mode_o,
  output logic                         core_pt_ld_en_o,
  output logic                         core_pt_run_en_o,
  output logic                         core_key_ld_en_o,
  output logic                         core_key_run_en_o,
  output logic [$clog2(UNROLL+1)-1:0]  core_rnds_o,
  output logic                         key_snap_o,
  output logic                         key_reg_sel_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic                         mode_o
);

  function automatic int simon_rounds(input int n, input int m);
    if (n == 16 && m == 4) return 32;
    if (n == 24 && m == 3) return 36;
    if (n == 24 && m == 4) return 36;
    if (n == 32 && m == 3) return 42;
    if (n == 32 && m == 4) return 44;
    if (n == 48 && m == 2) return 52;
    if (n == 48 && m == 3) return 54;
    if (n == 64 && m == 2) return 68;
    if (n == 64 && m == 3) return 69;
    if (n == 64 && m == 4) return 72;
    return 0;
  endfunction

  localparam int N_ROUNDS = simon_rounds(WW, NKW);
  localparam int CNT_W    = $clog2(N_ROUNDS + 1);
  localparam int RW       = $clog2(UNROLL + 1);

  if (N_ROUNDS == 0) begin : g_bad_cfg
    $error("simon_ctrl_seq: unsupported WW/NKW combination");
  end
  if (UNROLL < 1 || UNROLL > 8) begin : g_bad_unroll
    $error("simon_ctrl_seq: UNROLL must be within 1..8");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_ENC_PRE, S_ENC_RUN, S_DEC_PRE_KEY,
    S_DEC_KEY_RUN, S_DEC_PRE, S_DEC_RUN, S_OUTPUT
  } state_e;

  state_e           state;
  state_e           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [RW-1:0]    rnds_cur;
  logic [RW-1:0]    rnds_nxt;
  logic             last_step;
  logic             reuse_hit;

  function automatic logic is_pre(input state_e s);
    return (s == S_ENC_PRE) || (s == S_DEC_PRE_KEY) || (s == S_DEC_PRE);
  endfunction

  function automatic logic is_run(input state_e s);
    return (s == S_ENC_RUN) || (s == S_DEC_KEY_RUN) || (s == S_DEC_RUN);
  endfunction

  // Full UNROLL-sized steps until the remainder is smaller; only the final step is partial.
  function automatic logic [RW-1:0] step_rnds(input state_e s, input logic [CNT_W-1:0] c);
    int rem;
    rem = N_ROUNDS - int'(c);
    if (!is_run(s)) return '0;
    return (rem < UNROLL) ? RW'(rem) : RW'(UNROLL);
  endfunction

  assign rnds_cur  = step_rnds(state, cnt);
  assign last_step = is_run(state) && ((int'(cnt) + int'(rnds_cur)) == N_ROUNDS);
  assign cnt_nxt   = is_pre(state) ? '0 : cnt + CNT_W'(rnds_cur);
  assign rnds_nxt  = step_rnds(state_nxt, cnt_nxt);

`ifdef SIMON_CTRL_KEY_CACHE_EN
  logic cache_vld;
  assign reuse_hit = mode_i && key_reuse_i && cache_vld;
`else
  logic unused_key_reuse;
  assign unused_key_reuse = key_reuse_i;
  assign reuse_hit        = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (valid_i) begin
          if (!mode_i)        state_nxt = S_ENC_PRE;
          else if (reuse_hit) state_nxt = S_DEC_PRE;
          else                state_nxt = S_DEC_PRE_KEY;
        end
      end
      S_ENC_PRE:     state_nxt = S_ENC_RUN;
      S_DEC_PRE_KEY: state_nxt = S_DEC_KEY_RUN;
      S_DEC_PRE:     state_nxt = S_DEC_RUN;
      S_ENC_RUN:     if (last_step) state_nxt = S_OUTPUT;
      S_DEC_KEY_RUN: if (last_step) state_nxt = S_DEC_PRE;
      S_DEC_RUN:     if (last_step) state_nxt = S_OUTPUT;
      S_OUTPUT:      if (ready_i)   state_nxt = S_IDLE;
      default:       state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (srst) begin
      state             <= S_IDLE;
      cnt               <= '0;
      active_o          <= 1'b0;
      ready_o           <= 1'b0;
      core_srst_o       <= 1'b0;
      core_mode_o       <= 1'b0;
      core_pt_ld_en_o   <= 1'b0;
      core_pt_run_en_o  <= 1'b0;
      core_key_ld_en_o  <= 1'b0;
      core_key_run_en_o <= 1'b0;
      core_rnds_o       <= '0;
      key_snap_o        <= 1'b0;
      key_reg_sel_o     <= 1'b0;
      valid_o           <= 1'b0;
      mode_o            <= 1'b0;
`ifdef SIMON_CTRL_KEY_CACHE_EN
      cache_vld         <= 1'b0;
`endif
    end else begin
      state             <= state_nxt;
      cnt               <= cnt_nxt;
      active_o          <= (state_nxt != S_IDLE);
      ready_o           <= (state == S_ENC_PRE) || (state == S_DEC_PRE);
      core_srst_o       <= is_pre(state_nxt);
      core_key_ld_en_o  <= is_pre(state_nxt);
      core_pt_ld_en_o   <= (state_nxt == S_ENC_PRE) || (state_nxt == S_DEC_PRE);
      core_pt_run_en_o  <= (state_nxt == S_ENC_RUN) || (state_nxt == S_DEC_RUN);
      core_key_run_en_o <= is_run(state_nxt);
      core_mode_o       <= (state_nxt == S_DEC_PRE) || (state_nxt == S_DEC_RUN);
      key_reg_sel_o     <= (state_nxt == S_DEC_PRE);
      core_rnds_o       <= rnds_nxt;
      key_snap_o        <= (state_nxt == S_DEC_KEY_RUN) &&
                           ((int'(cnt_nxt) + int'(rnds_nxt)) == N_ROUNDS);
      valid_o           <= (state_nxt == S_OUTPUT);
      if (state_nxt == S_OUTPUT && state != S_OUTPUT)
        mode_o <= (state == S_DEC_RUN);
`ifdef SIMON_CTRL_KEY_CACHE_EN
      if (state == S_DEC_KEY_RUN && last_step)
        cache_vld <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_simon_ctrl_seq.sv
// Bench for simon_ctrl_seq (WW=64, NKW=3, UNROLL=4: 69 rounds, partial final step).
// Expected outputs come from per-job phase/latency arithmetic; key cache modelled when the macro is set.
module tb_simon_ctrl_seq;
  localparam int WW  = 64;
  localparam int NKW = 3;
  localparam int U   = 4;
  localparam int T   = 69;
  localparam int S   = (T + U - 1) / U;
  localparam int RW  = $clog2(U + 1);

  logic clk = 1'b0;
  logic srst, valid_i, mode_i, key_reuse_i, ready_i;
  logic active_o, ready_o, core_srst_o, core_mode_o, core_pt_ld_en_o, core_pt_run_en_o;
  logic core_key_ld_en_o, core_key_run_en_o, key_snap_o, key_reg_sel_o, valid_o, mode_o;
  logic [RW-1:0] core_rnds_o;

  always #5 clk = ~clk;

  simon_ctrl_seq #(.WW(WW), .NKW(NKW), .UNROLL(U)) dut (
    .clk(clk), .srst(srst), .active_o(active_o), .valid_i(valid_i), .ready_o(ready_o),
    .mode_i(mode_i), .key_reuse_i(key_reuse_i), .core_srst_o(core_srst_o),
    .core_mode_o(core_mode_o), .core_pt_ld_en_o(core_pt_ld_en_o),
    .core_pt_run_en_o(core_pt_run_en_o), .core_key_ld_en_o(core_key_ld_en_o),
    .core_key_run_en_o(core_key_run_en_o), .core_rnds_o(core_rnds_o),
    .key_snap_o(key_snap_o), .key_reg_sel_o(key_reg_sel_o), .valid_o(valid_o),
    .ready_i(ready_i), .mode_o(mode_o)
  );

  typedef struct packed {
    logic          active;
    logic          ready;
    logic          srst;
    logic          mode;
    logic          pt_ld;
    logic          pt_run;
    logic          key_ld;
    logic          key_run;
    logic [RW-1:0] rnds;
    logic          snap;
    logic          sel;
    logic          valid;
    logic          mode_o;
  } obs_t;

  obs_t obs;
  assign obs = {active_o, ready_o, core_srst_o, core_mode_o, core_pt_ld_en_o,
                core_pt_run_en_o, core_key_ld_en_o, core_key_run_en_o, core_rnds_o,
                key_snap_o, key_reg_sel_o, valid_o, mode_o};

  int tests = 0;
  int fails = 0;
  bit cache_m = 1'b0;
  bit mo_m    = 1'b0;

  function automatic int rmin(input int i);
    int r;
    r = T - i * U;
    return (r < U) ? r : U;
  endfunction

  // Expected outputs for cycle c of a job (cycle 0 = the cycle valid_i is sampled).
  function automatic obs_t job_exp(input int c, input bit full, input bit d, input bit mo);
    obs_t e;
    int   cd;
    e = '0;
    e.active = 1'b1;
    e.mode_o = mo;
    if (full && c <= S + 1) begin
      if (c == 1) begin
        e.srst = 1'b1; e.key_ld = 1'b1;
      end else begin
        e.key_run = 1'b1;
        e.rnds    = RW'(rmin(c - 2));
        e.snap    = (c - 2 == S - 1);
      end
      return e;
    end
    cd = full ? c - (S + 1) : c;
    if (cd == 1) begin
      e.srst = 1'b1; e.key_ld = 1'b1; e.pt_ld = 1'b1; e.mode = d; e.sel = d;
    end else if (cd <= S + 1) begin
      e.pt_run = 1'b1; e.key_run = 1'b1; e.mode = d;
      e.rnds   = RW'(rmin(cd - 2));
      e.ready  = (cd == 2);
    end else begin
      e.valid = 1'b1; e.mode_o = d;
    end
    return e;
  endfunction

  task automatic check(input string tag, input obs_t e);
    tests++;
    assert (obs === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic idle_cycle(input string tag);
    obs_t e;
    @(negedge clk);
    e = '0;
    e.mode_o = mo_m;
    check(tag, e);
  endtask

  // Runs one job from an idle cycle; rst_at > 0 asserts srst at that cycle instead of finishing.
  task automatic run_job(input int j, input bit m, input bit r, input int bp, input int rst_at);
    bit   hit, full;
    int   out_c;
    obs_t e;
`ifdef SIMON_CTRL_KEY_CACHE_EN
    hit = m && r && cache_m;
`else
    hit = 1'b0;
`endif
    full  = m && !hit;
    out_c = (full ? S + 1 : 0) + S + 2;
    valid_i = 1'b1; mode_i = m; key_reuse_i = r; ready_i = 1'b0;
    for (int c = 1; c <= out_c + bp; c++) begin
      @(negedge clk);
      e = job_exp(c, full, m, mo_m);
      check($sformatf("job%0d_c%0d", j, c), e);
      if (e.ready) begin
        valid_i = 1'b0; mode_i = 1'($urandom); key_reuse_i = 1'($urandom);
      end
      if (rst_at == c) begin
        srst = 1'b1; valid_i = 1'b0;
        @(negedge clk);
        srst = 1'b0; cache_m = 1'b0; mo_m = 1'b0;
        check($sformatf("job%0d_rst", j), '0);
        return;
      end
      if (c == out_c + bp) ready_i = 1'b1;
    end
    if (full) cache_m = 1'b1;
    mo_m = m;
    @(negedge clk);
    ready_i = 1'b0;
    e = '0;
    e.mode_o = mo_m;
    check($sformatf("job%0d_accept", j), e);
  endtask

  initial begin
    srst = 1'b1; valid_i = 1'b0; mode_i = 1'b0; key_reuse_i = 1'b0; ready_i = 1'b0;
    repeat (2) @(negedge clk);
    check("reset", '0);
    srst = 1'b0;
    idle_cycle("idle0");

    run_job(0, 1'b0, 1'b0, 0, 0);        // encrypt
    run_job(1, 1'b1, 1'b1, 5, 0);        // decrypt, cache empty, 5 cycles backpressure
    run_job(2, 1'b1, 1'b1, 1, 0);        // reuse request
    run_job(3, 1'b0, 1'b1, 2, 0);        // encrypt keeps the cache
    run_job(4, 1'b1, 1'b1, 0, 0);
    run_job(5, 1'b1, 1'b0, 0, S / 2);    // reset during the key pass
    run_job(6, 1'b1, 1'b1, 0, 0);        // cache invalid after reset
    idle_cycle("idle1");

    for (int j = 7; j < 31; j++) begin
      run_job(j, 1'($urandom), 1'($urandom), int'($urandom_range(0, 5)), 0);
      repeat ($urandom_range(0, 2)) idle_cycle($sformatf("gap%0d", j));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
